// File: rtl/tinyrisc_pkg.sv
// Shared loader state encoding, memory geometry defaults and word-assembly helper.
package tinyrisc_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;

  // Lowest address lands in the most significant byte (big-endian word).
  function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Program byte stream (valid/ready) plus the core's fetch port, bundled for the loader.
interface imem_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;

  modport master (
    output s_valid, s_data, s_last, fetch_addr,
    input  s_ready, fetch_data
  );

  modport slave (
    input  s_valid, s_data, s_last, fetch_addr,
    output s_ready, fetch_data
  );
endinterface

// File: rtl/imem_bytes.sv
// Byte-wide instruction store: one synchronous write port, four combinational read ports.
// Latency: write visible on reads right after the writing edge; reads are zero-cycle.
// Backpressure: none; caller gates the write enable.
module imem_bytes #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [AW-1:0] raddr3,
  output logic [7:0]    rdata0,
  output logic [7:0]    rdata1,
  output logic [7:0]    rdata2,
  output logic [7:0]    rdata3
);

  // Deliberately unreset: contents survive reset and are undefined until loaded.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
  assign rdata3 = mem[raddr3];

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction memory and holds the core until done.
// Latency: byte written and counted on its accepting edge; status outputs registered.
// Backpressure: s_ready high only in LOAD; no stall inside a load.
module imem_loader
  import tinyrisc_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_req,
  imem_loader_if.slave bus,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [AW:0]  byte_count,
  output logic [7:0]   load_sum
);

  ld_state_e   state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        s_ready_q, s_ready_d;
  logic        core_hold_q, core_hold_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;
  logic        accept;
  logic        mem_we;

  assign accept = bus.s_valid && s_ready_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    mem_we   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + (AW+1)'(1);
          sum_d = sum_q + bus.s_data;
          // Pointer top bit set means memory is full: the extra byte is an overflow.
          if (wr_ptr_q[AW]) begin
            state_d = ST_ERR;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (bus.s_last) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      default: begin
        if (load_req) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          cnt_d    = '0;
          sum_d    = '0;
        end
      end
    endcase
    s_ready_d   = (state_d == ST_LOAD);
    core_hold_d = (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
    load_err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      s_ready_q   <= 1'b0;
      core_hold_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      s_ready_q   <= s_ready_d;
      core_hold_q <= core_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign core_hold   = core_hold_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign byte_count  = cnt_q;
  assign load_sum    = sum_q;

  logic [AW-1:0] fa0, fa1, fa2, fa3;
  logic [7:0]    fb0, fb1, fb2, fb3;
  logic          unused_fetch_hi;

  // Fetch wraps within the memory; upper PC bits are don't-care.
  assign fa0 = bus.fetch_addr[AW-1:0];
  assign fa1 = fa0 + AW'(1);
  assign fa2 = fa0 + AW'(2);
  assign fa3 = fa0 + AW'(3);
  assign unused_fetch_hi = ^bus.fetch_addr[31:AW];

  imem_bytes #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (wr_ptr_q[AW-1:0]),
    .wdata  (bus.s_data),
    .raddr0 (fa0),
    .raddr1 (fa1),
    .raddr2 (fa2),
    .raddr3 (fa3),
    .rdata0 (fb0),
    .rdata1 (fb1),
    .rdata2 (fb2),
    .rdata3 (fb3)
  );

  assign bus.fetch_data = be_word(fb0, fb1, fb2, fb3);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set instruction memory size in bytes (power of two).
REQ-002 Parameter AW, default 8, SHALL set byte-address width, log2(DEPTH).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 load_req  input  1  SHALL be a single-cycle pulse that starts a program load.
REQ-006 s_valid  input  1  SHALL mark s_data/s_last valid.
REQ-007 s_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-008 s_data  input  8  SHALL be the program byte, stream order = ascending address.
REQ-009 s_last  input  1  SHALL mark the final byte of the program.
REQ-010 fetch_addr  input  32  SHALL be the fetch-side byte address (PC).
REQ-011 fetch_data  output  32  SHALL be the big-endian instruction word at fetch_addr.
REQ-012 core_hold  output  1  SHALL hold the core's PC/pipeline in reset while high.
REQ-013 load_done  output  1  SHALL be high while a load completed without error.
REQ-014 load_err  output  1  SHALL be high while the last load overflowed.
REQ-015 byte_count  output  AW+1  SHALL report bytes accepted in the current/last load.
REQ-016 load_sum  output  8  SHALL report the modulo-256 sum of bytes accepted.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE, ERR.
REQ-018 IDLE: s_ready=0, core_hold=1; load_req -> LOAD.
REQ-019 Entering LOAD SHALL clear write pointer, byte_count, load_sum; s_ready=1 throughout LOAD.
REQ-020 A byte SHALL be accepted only on a cycle with s_valid=1 and s_ready=1; it is written at the write pointer, pointer, byte_count and load_sum updated the same edge.
REQ-021 Accepted byte with s_last=1 SHALL move LOAD -> DONE on that edge.
REQ-022 Accepted byte number DEPTH+1 (pointer already at DEPTH) SHALL not be written and SHALL move LOAD -> ERR; a byte with s_last at count DEPTH is legal and goes to DONE.
REQ-023 load_req during LOAD SHALL be ignored.
REQ-024 load_req in DONE or ERR SHALL re-enter LOAD (core_hold reasserts next cycle).
REQ-025 core_hold SHALL be 0 only in DONE; load_done=1 only in DONE; load_err=1 only in ERR.
REQ-026 fetch_data SHALL be combinational: {mem[a], mem[a+1], mem[a+2], mem[a+3]}, a = fetch_addr[AW-1:0], increments wrapping modulo DEPTH; upper address bits ignored.
REQ-027 A byte written on edge N SHALL be visible on fetch_data after edge N.
REQ-028 fetch_data SHALL read memory in every state (no gating); core_hold guards use.

Reset
REQ-029 rst=0 SHALL force state IDLE, s_ready=0, core_hold=1, load_done=0, load_err=0, byte_count=0, load_sum=0, write pointer=0, immediately and independent of clk.
REQ-030 Reset mid-LOAD SHALL abandon the load; memory contents SHALL not be cleared by reset and are undefined until loaded.

Structure
REQ-031 State encoding, DEPTH/AW defaults SHALL live in a shared package (tinyrisc_pkg).
REQ-032 Byte memory SHALL be a sub-module imem_bytes: one synchronous write port, four combinational read ports.
REQ-033 FSM, pointer, counters and checksum SHALL reside in imem_loader.

Verification
REQ-034 Reset then load 8 bytes 00..07 (last on 07) -> DONE, byte_count=8, load_sum=0x1C, core_hold=0; fetch_addr=4 -> fetch_data=0x04050607.
REQ-035 s_valid toggling every other cycle during load of 4 bytes AA,BB,CC,DD -> only handshaked bytes written; fetch_addr=0x100 -> 0xAABBCCDD.
REQ-036 Load 256 bytes i=0..255, last on 255 -> DONE, byte_count=256; fetch_addr=0xFE -> 0xFEFF0001 (wrap).
REQ-037 Load 257 bytes without s_last -> ERR after byte 257, load_err=1, core_hold=1, mem[0] unchanged.
REQ-038 rst low after 3 bytes of a load -> IDLE asynchronously, s_ready=0, byte_count=0; fresh load_req restarts at address 0.
REQ-039 load_req pulsed mid-LOAD -> ignored, byte_count continues; load_req in DONE -> core_hold=1 next cycle, byte_count=0.
